// File: rtl/track_pkg.sv
// Shared types and helpers for the handwriting track bitmap.
// Recorder and display both map screen points through mirror().
package track_pkg;

  localparam int BSIZE      = 52;
  localparam int TRACK_BITS = BSIZE * BSIZE;

  typedef logic signed [11:0] coord_t;
  typedef logic signed [12:0] err_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1
  } state_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  localparam coord_t      STEP_POS = 12'sd1;
  localparam coord_t      STEP_NEG = -12'sd1;
  localparam coord_t      BSIZE_C  = 12'sd52;
  localparam logic [11:0] BSIZE_U  = 12'd52;

  function automatic coord_t mirror(
    input logic [9:0] lim,
    input logic [9:0] pos,
    input logic [9:0] org
  );
    coord_t l;
    coord_t p;
    coord_t o;
    l = {2'b00, lim};
    p = {2'b00, pos};
    o = {2'b00, org};
    return l - STEP_POS - p - o;
  endfunction

  function automatic logic in_block(input point_t pt);
    return !pt.x[11] && (pt.x < BSIZE_C) &&
           !pt.y[11] && (pt.y < BSIZE_C);
  endfunction

  function automatic logic [11:0] pix_idx(input point_t pt);
    return 12'(pt.y[5:0]) * BSIZE_U + 12'(pt.x[5:0]);
  endfunction

endpackage

// File: rtl/mouse_track_recorder_if.sv
// Mouse sample handshake between the PS/2 position logic
// and the track recorder.
interface mouse_track_recorder_if;

  logic       sample_valid;
  logic       sample_ready;
  logic [9:0] mouse_x;
  logic [9:0] mouse_y;
  logic       pen_down;

  modport master (
    output sample_valid,
    output mouse_x,
    output mouse_y,
    output pen_down,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  mouse_x,
    input  mouse_y,
    input  pen_down,
    output sample_ready
  );

endinterface

// File: rtl/track_line_stepper.sv
// Bresenham walker: load a segment, then one step per cycle
// until the current point reaches the end point.
module track_line_stepper
  import track_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   step,
  input  point_t from_pt,
  input  point_t to_pt,
  output point_t cur_pt,
  output logic   done
);

  point_t p0_q, p0_d;
  point_t p1_q, p1_d;
  err_t   dx_q, dx_d;
  err_t   dy_q, dy_d;
  err_t   err_q, err_d;
  logic   sx_neg_q, sx_neg_d;
  logic   sy_neg_q, sy_neg_d;

  err_t ddx, ddy, err_n;
  logic signed [13:0] e2, dx_w, dy_w;

  always_comb begin
    p0_d     = p0_q;
    p1_d     = p1_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;
    ddx      = err_t'(to_pt.x) - err_t'(from_pt.x);
    ddy      = err_t'(to_pt.y) - err_t'(from_pt.y);
    e2       = {err_q, 1'b0};
    dx_w     = {dx_q[12], dx_q};
    dy_w     = {dy_q[12], dy_q};
    err_n    = err_q;
    if (load) begin
      p0_d     = from_pt;
      p1_d     = to_pt;
      dx_d     = ddx[12] ? -ddx : ddx;
      dy_d     = ddy[12] ? ddy : -ddy;
      sx_neg_d = ddx[12];
      sy_neg_d = ddy[12];
      err_d    = dx_d + dy_d;
    end else if (step) begin
      if (e2 >= dy_w) begin
        err_n  = err_n + dy_q;
        p0_d.x = p0_q.x + (sx_neg_q ? STEP_NEG : STEP_POS);
      end
      if (e2 <= dx_w) begin
        err_n  = err_n + dx_q;
        p0_d.y = p0_q.y + (sy_neg_q ? STEP_NEG : STEP_POS);
      end
      err_d = err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_q     <= '0;
      p1_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      p0_q     <= p0_d;
      p1_q     <= p1_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      err_q    <= err_d;
      sx_neg_q <= sx_neg_d;
      sy_neg_q <= sy_neg_d;
    end
  end

  assign cur_pt = p0_q;
  assign done   = (p0_q == p1_q);

endmodule

// File: rtl/mouse_track_recorder.sv
// Writes pen strokes into the BSIZE x BSIZE track bitmap,
// joining consecutive pen-down samples with clipped lines.
module mouse_track_recorder
  import track_pkg::*;
#(
  parameter logic [9:0] H = 10'd480,
  parameter logic [9:0] W = 10'd640
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            block_x_pos,
  input  logic [9:0]            block_y_pos,
  mouse_track_recorder_if.slave sample_if,
  input  logic                  clear,
  output logic [TRACK_BITS-1:0] track,
  output logic                  busy,
  output logic                  nonempty
);

  state_t                  state_q, state_d;
  logic [TRACK_BITS-1:0]   track_q, track_d;
  logic                    nonempty_q, nonempty_d;
  point_t                  prev_q, prev_d;
  logic                    prev_valid_q, prev_valid_d;

  point_t new_pt, cur_pt, wr_pt;
  logic   wr_en, load, step, done, ready;

  track_line_stepper u_stepper (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .from_pt (prev_q),
    .to_pt   (new_pt),
    .cur_pt  (cur_pt),
    .done    (done)
  );

  always_comb begin
    new_pt.x     = mirror(W, sample_if.mouse_x, block_x_pos);
    new_pt.y     = mirror(H, sample_if.mouse_y, block_y_pos);
    state_d      = state_q;
    track_d      = track_q;
    nonempty_d   = nonempty_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_en        = 1'b0;
    wr_pt        = new_pt;
    load         = 1'b0;
    step         = 1'b0;
    ready        = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = !clear;
        if (clear) begin
          track_d      = '0;
          nonempty_d   = 1'b0;
          prev_valid_d = 1'b0;
        end else if (sample_if.sample_valid) begin
          if (!sample_if.pen_down) begin
            prev_valid_d = 1'b0;
          end else if (!prev_valid_q) begin
            wr_en        = 1'b1;
            prev_d       = new_pt;
            prev_valid_d = 1'b1;
          end else if (new_pt != prev_q) begin
            load    = 1'b1;
            state_d = DRAW;
          end
        end
      end
      DRAW: begin
        busy = 1'b1;
        if (clear) begin
          track_d      = '0;
          nonempty_d   = 1'b0;
          prev_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          wr_en = 1'b1;
          wr_pt = cur_pt;
          if (done) begin
            prev_d  = cur_pt;
            state_d = IDLE;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // clipped pixels still walk, they just never land
    if (wr_en && in_block(wr_pt)) begin
      track_d[pix_idx(wr_pt)] = 1'b1;
      nonempty_d              = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      track_q      <= '0;
      nonempty_q   <= 1'b0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      track_q      <= track_d;
      nonempty_q   <= nonempty_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  assign sample_if.sample_ready = ready;
  assign track                  = track_q;
  assign nonempty               = nonempty_q;

endmodule
